// File: rtl/control_conjunto_reg.sv
// Register-file controller: clears x1..x31 after reset, serves two-operand reads and
// arbitrates load/ALU writebacks. Define CONTROL_REG_BYPASS_EN for acceptance-edge forwarding.
module control_conjunto_reg (
    input  logic        clk,
    input  logic        rst,

    input  logic        sol_valid,
    output logic        sol_listo,
    input  logic [4:0]  sol_rs1,
    input  logic [4:0]  sol_rs2,

    output logic        resp_valid,
    input  logic        resp_listo,
    output logic [31:0] resp_rs1,
    output logic [31:0] resp_rs2,

    input  logic        wb_mem_valid,
    input  logic [4:0]  wb_mem_rd,
    input  logic [31:0] wb_mem_dato,

    input  logic        wb_alu_valid,
    input  logic [4:0]  wb_alu_rd,
    input  logic [31:0] wb_alu_dato,
    output logic        wb_alu_listo,

    output logic        rf_hab_w,
    output logic [4:0]  rf_addr_w,
    output logic [31:0] rf_data_w,

    output logic        rf_hab_r,
    output logic [4:0]  rf_addr_r1,
    output logic [4:0]  rf_addr_r2,
    input  logic [31:0] rf_data_r1,
    input  logic [31:0] rf_data_r2
);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        LECTURA,
        RESP
    } estado_t;

    estado_t     estado;
    estado_t     estado_sig;
    logic [4:0]  init_cnt;
    logic        aceptado;
    logic [31:0] op_rs1;
    logic [31:0] op_rs2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            estado   <= INIT;
            init_cnt <= 5'd1;
        end else begin
            estado <= estado_sig;
            if (estado == INIT) begin
                init_cnt <= init_cnt + 5'd1;
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        estado_sig = estado;
        case (estado)
            INIT:    if (init_cnt == 5'd31) estado_sig = IDLE;
            IDLE:    if (aceptado) estado_sig = LECTURA;
            LECTURA: estado_sig = RESP;
            RESP:    if (resp_listo) estado_sig = IDLE;
            default: estado_sig = INIT;
        endcase
    end

    // Read side: the regfile samples the addresses at the acceptance edge.
    always_comb begin
        sol_listo  = rst && (estado == IDLE);
        aceptado   = sol_valid && sol_listo;
        rf_hab_r   = aceptado;
        rf_addr_r1 = sol_rs1;
        rf_addr_r2 = sol_rs2;
        resp_valid = (estado == RESP);
    end

    // Write side: init sweep owns the port, otherwise loads beat ALU writebacks.
    always_comb begin
        rf_hab_w     = 1'b0;
        rf_addr_w    = 5'd0;
        rf_data_w    = 32'd0;
        wb_alu_listo = 1'b0;
        if (rst) begin
            if (estado == INIT) begin
                rf_hab_w  = 1'b1;
                rf_addr_w = init_cnt;
            end else begin
                wb_alu_listo = !wb_mem_valid;
                if (wb_mem_valid) begin
                    rf_addr_w = wb_mem_rd;
                    rf_data_w = wb_mem_dato;
                    rf_hab_w  = (wb_mem_rd != 5'd0);
                end else if (wb_alu_valid) begin
                    rf_addr_w = wb_alu_rd;
                    rf_data_w = wb_alu_dato;
                    rf_hab_w  = (wb_alu_rd != 5'd0);
                end
            end
        end
    end

`ifdef CONTROL_REG_BYPASS_EN
    logic        byp_valid;
    logic [4:0]  byp_rd;
    logic [31:0] byp_dato;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;

    // Snapshot of whatever write commits on the same edge the regfile is read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            byp_valid <= 1'b0;
            byp_rd    <= 5'd0;
            byp_dato  <= 32'd0;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
        end else if (aceptado) begin
            byp_valid <= rf_hab_w;
            byp_rd    <= rf_addr_w;
            byp_dato  <= rf_data_w;
            rs1_q     <= sol_rs1;
            rs2_q     <= sol_rs2;
        end
    end

    always_comb begin
        op_rs1 = rf_data_r1;
        op_rs2 = rf_data_r2;
        if (byp_valid && (rs1_q != 5'd0) && (rs1_q == byp_rd)) op_rs1 = byp_dato;
        if (byp_valid && (rs2_q != 5'd0) && (rs2_q == byp_rd)) op_rs2 = byp_dato;
    end
`else
    always_comb begin
        op_rs1 = rf_data_r1;
        op_rs2 = rf_data_r2;
    end
`endif

    // NOTE: the response registers are reset explicitly so a dropped request never
    // leaves stale operand data visible after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_rs1 <= 32'd0;
            resp_rs2 <= 32'd0;
        end else if (estado == LECTURA) begin
            resp_rs1 <= op_rs1;
            resp_rs2 <= op_rs2;
        end
    end

endmodule

// File: tb/tb_control_conjunto_reg.sv
// Self-checking bench for control_conjunto_reg: table vectors, directed corner cases and
// randomized traffic against a transaction-level model with a behavioural regfile.
module tb_control_conjunto_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        sol_valid, sol_listo;
    logic [4:0]  sol_rs1, sol_rs2;
    logic        resp_valid, resp_listo;
    logic [31:0] resp_rs1, resp_rs2;
    logic        wb_mem_valid;
    logic [4:0]  wb_mem_rd;
    logic [31:0] wb_mem_dato;
    logic        wb_alu_valid, wb_alu_listo;
    logic [4:0]  wb_alu_rd;
    logic [31:0] wb_alu_dato;
    logic        rf_hab_w, rf_hab_r;
    logic [4:0]  rf_addr_w, rf_addr_r1, rf_addr_r2;
    logic [31:0] rf_data_w, rf_data_r1, rf_data_r2;

    always #5 clk = ~clk;

    control_conjunto_reg dut (
        .clk(clk), .rst(rst),
        .sol_valid(sol_valid), .sol_listo(sol_listo),
        .sol_rs1(sol_rs1), .sol_rs2(sol_rs2),
        .resp_valid(resp_valid), .resp_listo(resp_listo),
        .resp_rs1(resp_rs1), .resp_rs2(resp_rs2),
        .wb_mem_valid(wb_mem_valid), .wb_mem_rd(wb_mem_rd), .wb_mem_dato(wb_mem_dato),
        .wb_alu_valid(wb_alu_valid), .wb_alu_rd(wb_alu_rd), .wb_alu_dato(wb_alu_dato),
        .wb_alu_listo(wb_alu_listo),
        .rf_hab_w(rf_hab_w), .rf_addr_w(rf_addr_w), .rf_data_w(rf_data_w),
        .rf_hab_r(rf_hab_r), .rf_addr_r1(rf_addr_r1), .rf_addr_r2(rf_addr_r2),
        .rf_data_r1(rf_data_r1), .rf_data_r2(rf_data_r2)
    );

    // Behavioural regfile: synchronous read-before-write, x0 reads as zero.
    logic [31:0] rf_mem [32];
    always @(posedge clk) begin
        if (rf_hab_r) begin
            rf_data_r1 <= (rf_addr_r1 == 5'd0) ? 32'd0 : rf_mem[rf_addr_r1];
            rf_data_r2 <= (rf_addr_r2 == 5'd0) ? 32'd0 : rf_mem[rf_addr_r2];
        end
        if (rf_hab_w) rf_mem[rf_addr_w] <= rf_data_w;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    // Transaction-level model: architectural registers plus one outstanding request.
    logic [31:0] ref_regs [32];
    bit          pend_active;
    int          pend_age;       // edges since (and including) acceptance
    logic [31:0] pend_e1, pend_e2;

    function automatic bit exp_resp();
        return pend_active && (pend_age >= 2);
    endfunction

    // Advance the model over the coming edge using the inputs now driven, then wait.
    task automatic step();
        bit          acc, wv;
        logic [4:0]  wrd;
        logic [31:0] wd;
        acc = rst && !pend_active && sol_valid;
        wv  = 1'b0;
        wrd = 5'd0;
        wd  = 32'd0;
        if (wb_mem_valid) begin
            wv = (wb_mem_rd != 5'd0); wrd = wb_mem_rd; wd = wb_mem_dato;
        end else if (wb_alu_valid) begin
            wv = (wb_alu_rd != 5'd0); wrd = wb_alu_rd; wd = wb_alu_dato;
        end
        if (pend_active) begin
            if (pend_age >= 2 && resp_listo) pend_active = 1'b0;
            else pend_age++;
        end
        if (acc) begin
            pend_e1 = ref_regs[sol_rs1];
            pend_e2 = ref_regs[sol_rs2];
`ifdef CONTROL_REG_BYPASS_EN
            if (wv && sol_rs1 == wrd) pend_e1 = wd;
            if (wv && sol_rs2 == wrd) pend_e2 = wd;
`endif
            pend_active = 1'b1;
            pend_age    = 1;
        end
        if (wv) ref_regs[wrd] = wd;
        @(negedge clk);
    endtask

    task automatic clear_wb();
        wb_mem_valid = 1'b0;
        wb_alu_valid = 1'b0;
    endtask

    // Called at a negedge right after rst was raised.
    task automatic run_init();
        int bad;
        for (int r = 0; r < 32; r++) ref_regs[r] = 32'd0;
        pend_active = 1'b0;
        wb_mem_valid = 1'b1; wb_mem_rd = 5'd9; wb_mem_dato = 32'h55;
        wb_alu_valid = 1'b1; wb_alu_rd = 5'd10; wb_alu_dato = 32'h66;
        for (int i = 1; i <= 31; i++) begin
            #1;
            check1("init rf_hab_w", rf_hab_w, 1'b1);
            check("init rf_addr_w", 32'(rf_addr_w), i);
            check("init rf_data_w", rf_data_w, 32'd0);
            check1("init sol_listo", sol_listo, 1'b0);
            check1("init wb_alu_listo", wb_alu_listo, 1'b0);
            @(negedge clk);
        end
        clear_wb();
        #1;
        check1("post-init sol_listo", sol_listo, 1'b1);
        check1("post-init rf_hab_w", rf_hab_w, 1'b0);
        bad = 0;
        for (int r = 1; r < 32; r++) if (rf_mem[r] !== 32'd0) bad++;
        check("init cleared regs", 32'(bad), 32'd0);
    endtask

    task automatic do_read(input string name, input logic [4:0] a, input logic [4:0] b,
                           input logic [31:0] e1, input logic [31:0] e2);
        sol_valid = 1'b1; sol_rs1 = a; sol_rs2 = b;
        #1;
        check1({name, " sol_listo"}, sol_listo, 1'b1);
        check1({name, " rf_hab_r"}, rf_hab_r, 1'b1);
        step();
        sol_valid = 1'b0;
        #1;
        check1({name, " resp_valid early"}, resp_valid, 1'b0);
        check1({name, " busy sol_listo"}, sol_listo, 1'b0);
        step();
        #1;
        check1({name, " resp_valid"}, resp_valid, 1'b1);
        check({name, " resp_rs1"}, resp_rs1, e1);
        check({name, " resp_rs2"}, resp_rs2, e2);
        resp_listo = 1'b1;
        step();
        resp_listo = 1'b0;
    endtask

    typedef struct {
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        e_hab;
        logic        chk_bus;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_listo;
    } vec_t;

    vec_t vecs [8];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 5'd3,  32'hA,        1'b1, 5'd4, 32'hB,  1'b1, 1'b1, 5'd3,  32'hA,        1'b0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4, 32'hB,  1'b1, 1'b1, 5'd4,  32'hB,        1'b1};
        vecs[2] = '{1'b1, 5'd0,  32'h5,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd0,  32'h5,        1'b0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h7,  1'b0, 1'b1, 5'd0,  32'h7,        1'b1};
        vecs[4] = '{1'b1, 5'd0,  32'h9,        1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 5'd0,  32'h9,        1'b0};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0,  32'h0,        1'b1};
        vecs[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd1, 32'h11, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd1, 32'h11, 1'b1, 1'b1, 5'd1,  32'h11,       1'b1};

        rst = 1'b0; sol_valid = 1'b1; sol_rs1 = 5'd1; sol_rs2 = 5'd2; resp_listo = 1'b0;
        wb_mem_valid = 1'b0; wb_mem_rd = 5'd0; wb_mem_dato = 32'd0;
        wb_alu_valid = 1'b1; wb_alu_rd = 5'd2; wb_alu_dato = 32'h1;
        repeat (2) @(negedge clk);
        #1;
        check1("reset rf_hab_w", rf_hab_w, 1'b0);
        check1("reset rf_hab_r", rf_hab_r, 1'b0);
        check1("reset sol_listo", sol_listo, 1'b0);
        check1("reset wb_alu_listo", wb_alu_listo, 1'b0);
        check1("reset resp_valid", resp_valid, 1'b0);
        check("reset resp_rs1", resp_rs1, 32'd0);
        check("reset resp_rs2", resp_rs2, 32'd0);
        sol_valid = 1'b0;
        clear_wb();
        @(negedge clk);
        rst = 1'b1;
        run_init();

        // ALU write then read back, rs2=x0
        wb_alu_valid = 1'b1; wb_alu_rd = 5'd5; wb_alu_dato = 32'h12345678;
        #1 check1("x5 wb_alu_listo", wb_alu_listo, 1'b1);
        step();
        clear_wb();
        do_read("x5", 5'd5, 5'd0, 32'h12345678, 32'd0);

        // Write arbitration table
        for (int v = 0; v < 8; v++) begin
            wb_mem_valid = vecs[v].mv; wb_mem_rd = vecs[v].mrd; wb_mem_dato = vecs[v].md;
            wb_alu_valid = vecs[v].av; wb_alu_rd = vecs[v].ard; wb_alu_dato = vecs[v].ad;
            #1;
            check1($sformatf("vec%0d rf_hab_w", v), rf_hab_w, vecs[v].e_hab);
            check1($sformatf("vec%0d wb_alu_listo", v), wb_alu_listo, vecs[v].e_listo);
            if (vecs[v].chk_bus) begin
                check($sformatf("vec%0d rf_addr_w", v), 32'(rf_addr_w), 32'(vecs[v].e_addr));
                check($sformatf("vec%0d rf_data_w", v), rf_data_w, vecs[v].e_data);
            end
            step();
        end
        clear_wb();
        do_read("x3x4", 5'd3, 5'd4, 32'hA, 32'hB);
        do_read("x31x1", 5'd31, 5'd1, 32'hFFFFFFFF, 32'h11);
        do_read("x9 not written", 5'd9, 5'd0, 32'd0, 32'd0);

        // Write colliding with the acceptance edge
        wb_alu_valid = 1'b1; wb_alu_rd = 5'd7; wb_alu_dato = 32'h1;
        step();
        wb_alu_dato = 32'hDEAD;
        sol_valid = 1'b1; sol_rs1 = 5'd7; sol_rs2 = 5'd0;
        #1 check1("collide sol_listo", sol_listo, 1'b1);
        step();
        sol_valid = 1'b0;
        clear_wb();
        step();
        #1;
        check1("collide resp_valid", resp_valid, 1'b1);
`ifdef CONTROL_REG_BYPASS_EN
        check("collide resp_rs1", resp_rs1, 32'hDEAD);
`else
        check("collide resp_rs1", resp_rs1, 32'h1);
`endif
        check("collide resp_rs2", resp_rs2, 32'd0);
        resp_listo = 1'b1;
        step();
        resp_listo = 1'b0;
        do_read("x7 after collide", 5'd7, 5'd0, 32'hDEAD, 32'd0);

        // Response held while consumer stalls and rs1 is rewritten
        sol_valid = 1'b1; sol_rs1 = 5'd6; sol_rs2 = 5'd7;
        step();
        sol_valid = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            wb_alu_valid = 1'b1; wb_alu_rd = 5'd6; wb_alu_dato = 32'h600 + 32'(k);
            #1;
            check1("hold resp_valid", resp_valid, 1'b1);
            check("hold resp_rs1", resp_rs1, 32'd0);
            check("hold resp_rs2", resp_rs2, 32'hDEAD);
            check1("hold sol_listo", sol_listo, 1'b0);
            step();
        end
        clear_wb();
        resp_listo = 1'b1;
        #1 check("hold resp_rs1 release", resp_rs1, 32'd0);
        step();
        resp_listo = 1'b0;
        do_read("x6 after hold", 5'd6, 5'd7, 32'h604, 32'hDEAD);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            sol_valid    = 1'($urandom_range(0, 1));
            sol_rs1      = 5'($urandom_range(0, 7));
            sol_rs2      = 5'($urandom_range(0, 7));
            wb_mem_valid = ($urandom_range(0, 3) == 0);
            wb_mem_rd    = 5'($urandom_range(0, 7));
            wb_mem_dato  = $urandom;
            wb_alu_valid = 1'($urandom_range(0, 1));
            wb_alu_rd    = 5'($urandom_range(0, 7));
            wb_alu_dato  = $urandom;
            resp_listo   = 1'($urandom_range(0, 1));
            #1;
            check1("rnd sol_listo", sol_listo, !pend_active);
            check1("rnd resp_valid", resp_valid, exp_resp());
            check1("rnd wb_alu_listo", wb_alu_listo, !wb_mem_valid);
            if (exp_resp()) begin
                check("rnd resp_rs1", resp_rs1, pend_e1);
                check("rnd resp_rs2", resp_rs2, pend_e2);
            end
            step();
        end

        // Drain, then reset in the middle of LECTURA
        sol_valid = 1'b0; resp_listo = 1'b1;
        clear_wb();
        repeat (3) step();
        resp_listo = 1'b0;
        sol_valid = 1'b1; sol_rs1 = 5'd5; sol_rs2 = 5'd6;
        #1 check1("midrst sol_listo", sol_listo, 1'b1);
        step();
        sol_valid = 1'b0;
        rst = 1'b0;
        wb_alu_valid = 1'b1; wb_alu_rd = 5'd5; wb_alu_dato = 32'h77;
        #1;
        check1("midrst rf_hab_w", rf_hab_w, 1'b0);
        check1("midrst wb_alu_listo", wb_alu_listo, 1'b0);
        @(negedge clk);
        #1;
        check1("midrst resp_valid", resp_valid, 1'b0);
        check("midrst resp_rs1", resp_rs1, 32'd0);
        clear_wb();
        @(negedge clk);
        #1 check1("midrst resp_valid later", resp_valid, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        run_init();
        do_read("after reinit", 5'd5, 5'd6, 32'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
